// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath and its result serializer:
// FSM states, default result width and the byte-count helper.
package mac_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam int MAC_RESULT_W = 24;

    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Small synchronous FIFO holding zero-padded MAC results ahead of the serializer.
// Caller guarantees push only when !full and pop only when !empty.
module mac_result_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: storage is deliberately not reset; only pointers and count define
    // validity, so resetting the array would just add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/mac_result_serializer.sv
// Buffers MAC results and streams each one LSB-first as a byte frame with last marker.
// Define MAC_SER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module mac_result_serializer
    import mac_pkg::*;
#(
    parameter int RESULT_W   = MAC_RESULT_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RESULT_W-1:0] res_data,
    input  logic                res_valid,
    output logic                res_ready,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    output logic                byte_last,
    input  logic                byte_ready,
    output logic                busy
);
    localparam int NBYTES = nbytes(RESULT_W);
    localparam int PAD_W  = 8 * NBYTES;
`ifdef MAC_SER_CHECKSUM_EN
    localparam int FRAME_LEN = NBYTES + 1;
`else
    localparam int FRAME_LEN = NBYTES;
`endif
    localparam int IDX_W = $clog2(FRAME_LEN + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [PAD_W-1:0] head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             xfer;
    logic             at_last;
    logic [7:0]       data_byte;

    assign res_ready  = !fifo_full;
    assign push       = res_valid && res_ready;
    assign byte_valid = (state == S_SEND);
    assign xfer       = byte_valid && byte_ready;
    assign at_last    = (idx == LAST_IDX);
    assign pop        = xfer && at_last;

    mac_result_fifo #(
        .WIDTH(PAD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .wr_data(PAD_W'(res_data)),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        data_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IDX_W'(i)) data_byte = head[8*i +: 8];
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_SEND;
                    idx_next   = '0;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (at_last) begin
                        idx_next = '0;
                        // Another result remains after this pop: chain frames without a gap.
                        state_next = ((fifo_count > CNT_W'(1)) || push) ? S_SEND : S_IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

`ifdef MAC_SER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst || pop) begin
            csum <= 8'h00;
        end else if (xfer) begin
            csum <= csum ^ data_byte;
        end
    end

    assign byte_out = !byte_valid ? 8'h00 :
                      (idx == IDX_W'(NBYTES)) ? csum : data_byte;
`else
    assign byte_out = byte_valid ? data_byte : 8'h00;
`endif

    assign byte_last = byte_valid && at_last;
    assign busy      = !fifo_empty || byte_valid;

endmodule

// File: doc/mac_result_serializer.md
Name: mac_result_serializer

Overview:
- Downstream stage of mac_test: takes each wide accumulator result the MAC produces and streams it out as bytes on the 8-bit output pins.
- Results enter over a valid/ready handshake and are buffered in a small FIFO.
- Each result is emitted LSB-first as a frame of bytes, with per-byte valid/ready and a last-byte marker.
- Decouples MAC throughput from a slow pin-side consumer.

Parameters:
- RESULT_W, 24, accumulator result width in bits; 8..32. NBYTES = ceil(RESULT_W/8).
- FIFO_DEPTH, 2, result buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- res_data  in  RESULT_W  MAC accumulator result.
- res_valid  in  1  res_data valid.
- res_ready  out  1  block can accept a result; = !fifo_full (registered-state derived).
- byte_out  out  8  current output byte.
- byte_valid  out  1  byte_out valid.
- byte_last  out  1  byte_out is the final byte of the frame.
- byte_ready  in  1  consumer accepts byte_out this cycle.
- busy  out  1  FIFO non-empty or a frame is in progress.

Behaviour:
- Reset (rst=1 at an edge) clears:
  - FIFO pointers/count; FIFO storage contents are don't-care.
  - byte index and state, returning to IDLE.
- After reset: res_ready=1, byte_out=0, byte_valid=0, byte_last=0, busy=0.
- Push: res_valid && res_ready at an edge writes res_data into the tail.
  - Bits above RESULT_W in the last byte are zero-padded.
- res_ready depends only on the FIFO count at the start of the cycle.
  - When full, a pop in the same cycle does NOT enable a push; the push waits one cycle.
- FSM, IDLE and SEND:
  - IDLE -> SEND on the edge where the FIFO is non-empty. Byte index is set to 0.
  - Latency: a result pushed into an empty FIFO at edge N gives byte_valid=1 from edge N+1.
  - SEND: byte_out = head[8*idx +: 8] (registered), byte_valid=1, byte_last = (idx==NBYTES-1).
  - A byte transfers when byte_valid && byte_ready. Each transfer increments idx.
  - On transfer of the last byte: pop the head and reset idx to 0.
  - After the last byte: if the FIFO still holds an entry (count after pop > 0), stay in SEND and present byte 0 of the next result on the next cycle (back-to-back frames, no bubble). Otherwise go to IDLE.
- Simultaneous push and pop (not full): both occur; count unchanged.
- Push into an empty FIFO while a pop happens cannot occur, because a pop requires a non-empty FIFO.
- byte_valid never drops while waiting on byte_ready.
- byte_out, byte_last must hold stable until the transfer.
- In IDLE, byte_out=0 and byte_last=0.
- Reset mid-frame:
  - The partial frame is abandoned and all buffered results are discarded.
  - byte_valid=0 on the cycle after the reset edge.
- busy = (count != 0) || (state == SEND).

Optional Feature:
- Macro: MAC_SER_CHECKSUM_EN.
- Defined: each frame gets one extra byte after the NBYTES data bytes.
  - The extra byte is the XOR of all data bytes of that frame.
  - byte_last asserts on the checksum byte, not the last data byte.
  - Frame length = NBYTES+1. Checksum is accumulated as bytes transfer and cleared at frame start.
- Undefined: no checksum logic is present; frame length = NBYTES.

Decomposition:
- Shared package mac_pkg:
  - FSM state enum (S_IDLE, S_SEND).
  - Default RESULT_W constant shared with mac_test.
  - NBYTES calculation function.
- One sub-module: mac_result_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by width and depth.
- Serializer FSM, byte index counter and checksum live in the top module.

Test Plan (all with RESULT_W=24 unless stated):
- Reset then idle: after rst, res_ready=1, byte_valid=0, busy=0, byte_out=0, held for 5 cycles.
- Single result, byte_ready=1: push 0xABCDEF at edge N; bytes EF, CD, AB appear on edges N+1..N+3; byte_last=1 only on AB; busy=0 after the last transfer.
- Backpressure: push 0x123456 with byte_ready=0 for 4 cycles; byte_out=0x56 and byte_valid=1 stay stable; then ready=1 yields 56, 34, 12.
- Full FIFO: push 3 results back-to-back with byte_ready=0; the third push sees res_ready=0 and waits. Release byte_ready; all 9 bytes arrive in order with no bubbles between frames.
- Reset mid-frame: assert rst after byte 1 of 0x0A0B0C with a second result queued; next cycle byte_valid=0, busy=0, and no further bytes appear.
- MAC_SER_CHECKSUM_EN: push 0x010203; bytes 03, 02, 01, then 00 with byte_last on 00. Push 0xFF00F0; bytes F0, 00, FF, then 0F.
